// File: rtl/usb4_lane_train_ctrl.sv
// usb4_lane_train_ctrl: USB4 Gen4 lane-training FSM with TS1/TS2 counting, retry escalation and timer enables
module usb4_lane_train_ctrl #(
  parameter int TS1_RX_NEEDED = 2,
  parameter int TS2_RX_NEEDED = 8,
  parameter int RETRY_LIMIT = 3
) (
  input  logic       clk_b,
  input  logic       rst,
  input  logic       disable_req,
  input  logic       tdisconnect_tx_min,
  input  logic       tconnect_rx_min,
  input  logic       tdisconnect_rx_min,
  input  logic       tdisabled_min,
  input  logic       ttraining_error_timeout,
  input  logic       tgen4_ts1_timeout,
  input  logic       tgen4_ts2_timeout,
  input  logic       ts1_rcvd,
  input  logic       ts2_rcvd,
  output logic       disconnected_s,
  output logic       fsm_disabled,
  output logic       fsm_training,
  output logic       ts1_gen4_s,
  output logic       ts2_gen4_s,
  output logic       cl0_s,
  output logic [2:0] state,
  output logic       retry_fail
);
  localparam int C1W = $clog2(TS1_RX_NEEDED + 1);
  localparam int C2W = $clog2(TS2_RX_NEEDED + 1);
  localparam int RW = $clog2(RETRY_LIMIT + 1);
  typedef enum logic [2:0] {
    DISCONNECT = 3'd0, CONNECT_WAIT = 3'd1, TS1 = 3'd2, TS2 = 3'd3, CL0 = 3'd4, DISABLED = 3'd5
  } state_t;
  state_t cur, nxt;
  logic [C1W-1:0] ts1_cnt;
  logic [C2W-1:0] ts2_cnt;
  logic [RW-1:0] retry_cnt;
  logic lost, fail, fail_win, exhaust, ts1_done, ts2_done, dis_exit;
  always_comb begin
    lost = tdisconnect_rx_min && (cur == TS1 || cur == TS2 || cur == CL0);
    fail = (cur == TS1 && (ttraining_error_timeout || tgen4_ts1_timeout)) ||
           (cur == TS2 && (ttraining_error_timeout || tgen4_ts2_timeout));
    fail_win = fail && !lost && !disable_req;
    exhaust = retry_cnt == RW'(RETRY_LIMIT - 1);
    ts1_done = ts1_rcvd && ts1_cnt == C1W'(TS1_RX_NEEDED - 1);
    ts2_done = ts2_rcvd && ts2_cnt == C2W'(TS2_RX_NEEDED - 1);
    dis_exit = cur == DISABLED && tdisabled_min && !disable_req;
    nxt = DISCONNECT;
    case (cur)
      DISCONNECT:   nxt = tdisconnect_tx_min ? CONNECT_WAIT : DISCONNECT;
      CONNECT_WAIT: nxt = tconnect_rx_min ? TS1 : CONNECT_WAIT;
      TS1:          nxt = ts1_done ? TS2 : TS1;
      TS2:          nxt = ts2_done ? CL0 : TS2;
      CL0:          nxt = CL0;
      DISABLED:     nxt = dis_exit ? DISCONNECT : DISABLED;
      default:      nxt = DISCONNECT;
    endcase
    if (fail) nxt = exhaust ? DISABLED : DISCONNECT;
    if (lost) nxt = DISCONNECT;
    if (disable_req && cur != DISABLED) nxt = DISABLED;
    if (cur > DISABLED) nxt = DISCONNECT;
  end
  always_ff @(posedge clk_b) begin
    if (rst) begin
      cur <= DISCONNECT;
      ts1_cnt <= '0;
      ts2_cnt <= '0;
      retry_cnt <= '0;
      retry_fail <= 1'b0;
    end else begin
      cur <= nxt;
      ts1_cnt <= (nxt != cur) ? '0 :
                 (cur == TS1 && ts1_rcvd && ts1_cnt != C1W'(TS1_RX_NEEDED)) ? ts1_cnt + C1W'(1) : ts1_cnt;
      ts2_cnt <= (nxt != cur) ? '0 :
                 (cur == TS2 && ts2_rcvd && ts2_cnt != C2W'(TS2_RX_NEEDED)) ? ts2_cnt + C2W'(1) : ts2_cnt;
      retry_cnt <= fail_win ? (exhaust ? '0 : retry_cnt + RW'(1)) :
                   ((nxt == CL0 && cur != CL0) || (dis_exit && nxt == DISCONNECT)) ? '0 : retry_cnt;
      retry_fail <= (fail_win && exhaust) ? 1'b1 : (dis_exit && nxt == DISCONNECT) ? 1'b0 : retry_fail;
    end
  end
  assign state = cur;
  assign disconnected_s = cur == DISCONNECT;
  assign fsm_disabled = cur == DISABLED;
  assign fsm_training = cur == TS1 || cur == TS2;
  assign ts1_gen4_s = cur == TS1;
  assign ts2_gen4_s = cur == TS2;
  assign cl0_s = cur == CL0;
endmodule

// File: tb/tb_usb4_lane_train_ctrl.sv
// tb_usb4_lane_train_ctrl: directed scoreboard bench for the lane-training controller
module tb_usb4_lane_train_ctrl;
  localparam logic [10:0] RST = 11'h400, DIS = 11'h200, TTX = 11'h100, TCRX = 11'h080, TDRX = 11'h040,
                          TDIS = 11'h020, TTE = 11'h010, T1TO = 11'h008, T2TO = 11'h004, R1 = 11'h002,
                          R2 = 11'h001, NONE = 11'h000;
  logic clk_b = 1'b0;
  logic rst, disable_req, tdisconnect_tx_min, tconnect_rx_min, tdisconnect_rx_min, tdisabled_min;
  logic ttraining_error_timeout, tgen4_ts1_timeout, tgen4_ts2_timeout, ts1_rcvd, ts2_rcvd;
  logic disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s, cl0_s, retry_fail;
  logic [2:0] state;
  logic [3:0] sb[$];
  int tests = 0;
  int fails = 0;
  always #5 clk_b = ~clk_b;
  usb4_lane_train_ctrl dut (
    .clk_b(clk_b), .rst(rst), .disable_req(disable_req), .tdisconnect_tx_min(tdisconnect_tx_min),
    .tconnect_rx_min(tconnect_rx_min), .tdisconnect_rx_min(tdisconnect_rx_min),
    .tdisabled_min(tdisabled_min), .ttraining_error_timeout(ttraining_error_timeout),
    .tgen4_ts1_timeout(tgen4_ts1_timeout), .tgen4_ts2_timeout(tgen4_ts2_timeout),
    .ts1_rcvd(ts1_rcvd), .ts2_rcvd(ts2_rcvd), .disconnected_s(disconnected_s),
    .fsm_disabled(fsm_disabled), .fsm_training(fsm_training), .ts1_gen4_s(ts1_gen4_s),
    .ts2_gen4_s(ts2_gen4_s), .cl0_s(cl0_s), .state(state), .retry_fail(retry_fail)
  );
  task automatic step(input logic [10:0] v, input logic [2:0] es, input logic erf);
    logic [3:0] e;
    logic [9:0] obs, want;
    {rst, disable_req, tdisconnect_tx_min, tconnect_rx_min, tdisconnect_rx_min, tdisabled_min,
     ttraining_error_timeout, tgen4_ts1_timeout, tgen4_ts2_timeout, ts1_rcvd, ts2_rcvd} = v;
    sb.push_back({es, erf});
    @(posedge clk_b);
    #1;
    e = sb.pop_front();
    want = {e[3:1], e[3:1] == 3'd0, e[3:1] == 3'd5, e[3:1] == 3'd2 || e[3:1] == 3'd3,
            e[3:1] == 3'd2, e[3:1] == 3'd3, e[3:1] == 3'd4, e[0]};
    obs = {state, disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s, cl0_s, retry_fail};
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL step%0d in=%b {state,dis,dsb,trn,ts1,ts2,cl0,rf} got=%b want=%b", tests, v, obs, want);
    end
  endtask
  task automatic to_ts1();
    step(TTX, 3'd1, 1'b0);
    step(TCRX, 3'd2, 1'b0);
  endtask
  task automatic to_ts2_last();
    to_ts1();
    step(R1, 3'd2, 1'b0);
    step(R1, 3'd3, 1'b0);
    for (int i = 0; i < 7; i++) step(R2, 3'd3, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    step(RST, 3'd0, 1'b0);
    step(RST, 3'd0, 1'b0);
    step(NONE, 3'd0, 1'b0);
    step(TTX, 3'd1, 1'b0);
    step(NONE, 3'd1, 1'b0);
    step(TCRX, 3'd2, 1'b0);
    step(R2, 3'd2, 1'b0);
    step(R1, 3'd2, 1'b0);
    step(R1, 3'd3, 1'b0);
    step(R1, 3'd3, 1'b0);
    for (int i = 0; i < 7; i++) step(R2, 3'd3, 1'b0);
    step(R2, 3'd4, 1'b0);
    step(R1 | R2, 3'd4, 1'b0);
    step(TDRX, 3'd0, 1'b0);
    to_ts1();
    step(R1, 3'd2, 1'b0);
    step(T1TO, 3'd0, 1'b0);
    to_ts1();
    step(T1TO | R1, 3'd0, 1'b0);
    to_ts1();
    step(T1TO, 3'd5, 1'b1);
    step(NONE, 3'd5, 1'b1);
    step(DIS | TDIS, 3'd5, 1'b1);
    step(TDIS, 3'd0, 1'b0);
    step(DIS, 3'd5, 1'b0);
    step(TDIS, 3'd0, 1'b0);
    to_ts2_last();
    step(R2 | T2TO, 3'd0, 1'b0);
    to_ts1();
    step(TTE, 3'd0, 1'b0);
    to_ts2_last();
    step(R2, 3'd4, 1'b0);
    step(DIS | TDRX, 3'd5, 1'b0);
    step(TDIS, 3'd0, 1'b0);
    to_ts1();
    step(T1TO, 3'd0, 1'b0);
    to_ts1();
    step(T1TO, 3'd0, 1'b0);
    to_ts1();
    step(TDRX, 3'd0, 1'b0);
    to_ts1();
    step(T2TO, 3'd2, 1'b0);
    step(T1TO, 3'd5, 1'b1);
    step(TDIS, 3'd0, 1'b0);
    to_ts1();
    step(R1, 3'd2, 1'b0);
    step(R1, 3'd3, 1'b0);
    step(R2, 3'd3, 1'b0);
    step(R2, 3'd3, 1'b0);
    step(RST | R2, 3'd0, 1'b0);
    to_ts2_last();
    step(R2, 3'd4, 1'b0);
    step(NONE, 3'd4, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb4_lane_train_ctrl.md
Name: usb4_lane_train_ctrl

Overview:
- Moore-style lane-training controller that sequences the lane through disconnect, connect-detect, Gen4 TS1/TS2 training, CL0 and disabled.
- Drives the enable inputs of the lane timer block (disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s) and consumes its min/timeout flags.
- Owns training retry accounting and escalates repeated failures to DISABLED.
- Sits between the timer, the TS ordered-set generator/detector and the link-management logic.

Parameters:
- TS1_RX_NEEDED, 2, TS1 pulses received in TS1 before advancing to TS2.
- TS2_RX_NEEDED, 8, TS2 pulses received in TS2 before entering CL0.
- RETRY_LIMIT, 3, failed training attempts before forced DISABLED.

Ports:
- clk_b  in  1  controller clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- disable_req  in  1  level; link manager requests disable.
- tdisconnect_tx_min  in  1  timer flag: minimum TX disconnect time met.
- tconnect_rx_min  in  1  timer flag: SBRX high long enough (connect).
- tdisconnect_rx_min  in  1  timer flag: SBRX low long enough (partner gone).
- tdisabled_min  in  1  timer flag: minimum disabled time met.
- ttraining_error_timeout  in  1  timer flag: overall training timeout.
- tgen4_ts1_timeout  in  1  timer flag: TS1 phase timeout.
- tgen4_ts2_timeout  in  1  timer flag: TS2 phase timeout.
- ts1_rcvd  in  1  1-cycle pulse per valid TS1 received.
- ts2_rcvd  in  1  1-cycle pulse per valid TS2 received.
- disconnected_s  out  1  timer enable; high in DISCONNECT.
- fsm_disabled  out  1  timer enable; high in DISABLED.
- fsm_training  out  1  timer enable; high in TS1 or TS2.
- ts1_gen4_s  out  1  timer enable and TS1 transmit request; high in TS1.
- ts2_gen4_s  out  1  timer enable and TS2 transmit request; high in TS2.
- cl0_s  out  1  high in CL0.
- state  out  3  encoding: DISCONNECT=0, CONNECT_WAIT=1, TS1=2, TS2=3, CL0=4, DISABLED=5.
- retry_fail  out  1  sticky; set on entry to DISABLED due to retry exhaustion.

Behaviour:
- Clock and reset: single clock clk_b. rst is synchronous, active-high.
- Reset state: state=DISCONNECT, rx counters=0, retry_cnt=0, retry_fail=0. Resulting outputs: disconnected_s=1, all other outputs 0.
- Reset mid-operation returns to DISCONNECT on the next edge, whatever the current state.
- Outputs are decoded purely from the state register (plus retry_fail). A state change is visible one cycle after the causing input.
- Transition priority each cycle, first match wins:
  - P1: disable_req=1 and state!=DISABLED -> DISABLED.
  - P2: tdisconnect_rx_min=1 in TS1/TS2/CL0 -> DISCONNECT. retry_cnt unchanged.
  - P3: in TS1/TS2, ttraining_error_timeout, or the phase timeout (TS1: tgen4_ts1_timeout; TS2: tgen4_ts2_timeout) -> fail.
  - P4: normal progress.
- Normal progress:
  - DISCONNECT -> CONNECT_WAIT when tdisconnect_tx_min=1.
  - CONNECT_WAIT -> TS1 when tconnect_rx_min=1.
  - TS1 -> TS2 on the edge where ts1_cnt would reach TS1_RX_NEEDED. The pulse arriving that cycle counts.
  - TS2 -> CL0 on the edge where ts2_cnt would reach TS2_RX_NEEDED.
  - CL0: hold until P1 or P2.
  - DISABLED -> DISCONNECT when tdisabled_min=1 and disable_req=0. retry_cnt and retry_fail clear on this exit.
- Fail handling: retry_cnt+1. If the new value equals RETRY_LIMIT: go to DISABLED, set retry_fail=1, clear retry_cnt. Otherwise go to DISCONNECT.
- Timeout vs final pulse: a timeout in the same cycle as the final ts*_rcvd pulse is a fail; the pulse is ignored.
- retry_cnt clears on entry to CL0.
- Counters:
  - ts1_cnt and ts2_cnt are $clog2(N+1) bits, saturating.
  - Both clear on every state transition.
  - ts1_rcvd is ignored outside TS1; ts2_rcvd is ignored outside TS2.
  - ts2_rcvd is ignored in TS1; this is no error.
- Dwell: DISCONNECT always lasts at least 1 cycle, so fsm_training drops for at least 1 cycle between attempts and the timer's training counter sees a gap.
- Illegal state encodings 6-7 -> DISCONNECT next cycle.

Test Plan:
- Clean bring-up: rst 2 cycles; tdisconnect_tx_min at cycle 3; tconnect_rx_min at 5; 2 ts1_rcvd pulses; 8 ts2_rcvd pulses -> state 0,1,2,3,4 in order; cl0_s=1 one cycle after 8th TS2; retry_cnt=0.
- TS1 timeout retry: in TS1 assert tgen4_ts1_timeout three times across attempts -> attempts 1-2 return to DISCONNECT; third enters DISABLED with retry_fail=1, fsm_disabled=1.
- Simultaneous events: in TS2 with ts2_cnt=7, assert ts2_rcvd and tgen4_ts2_timeout same cycle -> fail path to DISCONNECT, not CL0; in CL0 assert disable_req and tdisconnect_rx_min together -> DISABLED.
- Disable exit: in DISABLED hold disable_req=1 with tdisabled_min=1 -> remain; drop disable_req -> DISCONNECT next edge, retry_fail=0.
- Partner loss: in CL0 pulse tdisconnect_rx_min -> DISCONNECT, disconnected_s=1 next cycle, retry_cnt unchanged.
- Reset mid-TS2: assert rst in TS2 -> state=0, disconnected_s=1, all counters 0 next edge.
